arith_ctrl: RTL and testbench
=============================

// Module: arith_ctrl
// PURPOSE
// - Micro-sequencer directly upstream of the arithmetic unit: turns one op request from the op decoder into cycle-by-cycle do_*_from_ac strobes.
// - Consumes the unit's status bits (carry_out, reg_b0, reg_c30) to steer multi-cycle ops (SUB, MUL, shift).
// - Returns done/overflow to the decoder. Holds no datapath state, only FSM, step counter and flags.
// PARAMETERS
// - WORD_W  30  datapath width; sets the MUL iteration count.
// - CNT_W   5   step-counter width; must satisfy 2**CNT_W > WORD_W.
// PORTS
// - clk                        in   1      clock.
// - resetn                     in   1      asynchronous active-low reset.
// - start_from_op              in   1      op request; sampled only in IDLE.
// - op_sel_from_op             in   3      0 ADD, 1 SUB, 2 AND, 3 MUL, 4 SHLC; 5-7 are NOP.
// - shift_cnt_from_op          in   CNT_W  SHLC distance n.
// - carry_out_from_au          in   1      sum carry.
// - reg_b0_from_au             in   1      B sign/overflow bit.
// - reg_c30_from_au            in   1      C LSB, the MUL multiplier bit.
// - do_<x>_to_au               out  1      one strobe per unit command: clear_a/b/c, not_a, sum, and, right_shift_bc, move_b_to_c, left_shift_c, left_shift_c29.
// - busy_to_op                 out  1      high from the start-accept cycle to the done cycle, inclusive.
// - done_to_op                 out  1      one-cycle pulse at op end.
// - ovf_to_op                  out  1      overflow flag; see CONFIGURATION.
// BEHAVIOUR
// - Reset: state IDLE; every output 0; counter 0. Reset mid-op aborts at once and leaves no strobe pending.
// - All strobes are registered Moore outputs decoded from state.
// - At most one do_* is high per cycle. Sole exception: left_shift_c29 is high together with left_shift_c.
// - Start is accepted only in IDLE. While busy, start is ignored; it is neither queued nor errored.
// - ADD: SUM -> MOVE(b_to_c) -> DONE. done rises 3 cycles after start is sampled.
// - SUB: NOTA -> SUM -> MOVE -> DONE (4 cycles). NOTA relies on the unit setting carry_in to form the two's complement.
// - AND: AND -> DONE (2 cycles).
// - MUL: CLRB, then WORD_W iterations. Each iteration is TEST, then SUM only if reg_c30=1, then SHIFT (right_shift_bc).
//   - Counter loads WORD_W-1 in CLRB and decrements in SHIFT. Exit to DONE when it reaches 0 in SHIFT.
//   - Latency is 2 + 2*WORD_W + popcount(multiplier) cycles.
// - SHLC: n cycles of left_shift_c with left_shift_c29 high (internal shift, no IO fill), then DONE. n=0 goes straight to DONE (1 cycle).
// - NOP codes: DONE next cycle with no strobes.
// - DONE lasts one cycle (done_to_op=1), then IDLE. A start on the first IDLE cycle is accepted, so back-to-back ops run with no bubble beyond DONE.
// - Status inputs are sampled in the cycle after the strobe that produced them, i.e. TEST samples reg_c30 registered by the previous SHIFT.
// CONFIGURATION
// - Macro ARITH_CTRL_OVF_EN.
// - When defined:
//   - ovf_to_op captures carry_out_from_au in ADD/SUB SUM cycles.
//   - It captures reg_b0_from_au after each MUL SHIFT and ORs the result into the flag.
//   - Cleared on start accept; held after done until the next start.
// - When undefined: ovf_to_op is tied 0 and no flag flop exists.
// STRUCTURE
// - Package arith_ctrl_pkg holds:
//   - op_sel encodings (OP_ADD..OP_SHLC);
//   - the state enum (IDLE, NOTA, SUM, MOVE, AND, CLRB, TEST, SHIFT, SHLC, DONE);
//   - the WORD_W default.
// - One sub-module, arith_step_counter: load/decrement/zero-flag counter of width CNT_W, shared by MUL and SHLC.
// TESTING
// - Reset mid-MUL (resetn low in the 10th SHIFT): all strobes 0 in the same cycle; busy=0; the next start runs cleanly.
// - ADD with the unit holding A=0x3FFFFFFF, B=1: strobes sum, then move_b_to_c; done at cycle 3; C=0; with OVF_EN ovf=1.
// - SUB with A=5, B=7: not_a, sum, move; C=2; done at cycle 4.
// - MUL 3 x 5 (C=5): exactly 2 sum strobes and 30 right_shift_bc strobes; done at cycle 64.
// - SHLC n=4 then n=0: 4 consecutive left_shift_c+c29 cycles; the n=0 case pulses done 1 cycle after start.
// - Start held high through a MUL: only one op executes; a second ADD issued in the first IDLE cycle after done starts immediately.

Source files
------------

// File: rtl/arith_ctrl_pkg.sv
// arith_ctrl_pkg: op encodings, sequencer states and strobe bundle
// shared by the arithmetic-unit controller and its step counter.
package arith_ctrl_pkg;

  localparam int WORD_W_DEF = 30;
  localparam int CNT_W_DEF  = 5;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_SHLC = 3'd4;

  typedef enum logic [3:0] {
    IDLE, NOTA, SUM, MOVE, AND,
    CLRB, TEST, SHIFT, SHLC, DONE
  } state_t;

  typedef struct packed {
    logic clear_a;
    logic clear_b;
    logic clear_c;
    logic not_a;
    logic sum;
    logic and_ab;
    logic right_shift_bc;
    logic move_b_to_c;
    logic left_shift_c;
    logic left_shift_c29;
  } strobe_t;

  function automatic strobe_t decode(state_t s);
    strobe_t d;
    d = '0;
    d.clear_b        = (s == CLRB);
    d.not_a          = (s == NOTA);
    d.sum            = (s == SUM);
    d.and_ab         = (s == AND);
    d.right_shift_bc = (s == SHIFT);
    d.move_b_to_c    = (s == MOVE);
    d.left_shift_c   = (s == SHLC);
    d.left_shift_c29 = (s == SHLC);
    return d;
  endfunction

endpackage

// File: rtl/arith_ctrl_if.sv
// arith_ctrl_if: op-decoder request/response and arithmetic-unit
// strobe/status bundle around the arith_ctrl sequencer.
interface arith_ctrl_if #(
  parameter int CNT_W = arith_ctrl_pkg::CNT_W_DEF
);
  logic             start_from_op;
  logic [2:0]       op_sel_from_op;
  logic [CNT_W-1:0] shift_cnt_from_op;
  logic             carry_out_from_au;
  logic             reg_b0_from_au;
  logic             reg_c30_from_au;
  logic             do_clear_a_to_au;
  logic             do_clear_b_to_au;
  logic             do_clear_c_to_au;
  logic             do_not_a_to_au;
  logic             do_sum_to_au;
  logic             do_and_to_au;
  logic             do_right_shift_bc_to_au;
  logic             do_move_b_to_c_to_au;
  logic             do_left_shift_c_to_au;
  logic             do_left_shift_c29_to_au;
  logic             busy_to_op;
  logic             done_to_op;
  logic             ovf_to_op;

  modport master (
    output start_from_op, op_sel_from_op, shift_cnt_from_op,
    output carry_out_from_au, reg_b0_from_au, reg_c30_from_au,
    input  do_clear_a_to_au, do_clear_b_to_au, do_clear_c_to_au,
    input  do_not_a_to_au, do_sum_to_au, do_and_to_au,
    input  do_right_shift_bc_to_au, do_move_b_to_c_to_au,
    input  do_left_shift_c_to_au, do_left_shift_c29_to_au,
    input  busy_to_op, done_to_op, ovf_to_op
  );

  modport slave (
    input  start_from_op, op_sel_from_op, shift_cnt_from_op,
    input  carry_out_from_au, reg_b0_from_au, reg_c30_from_au,
    output do_clear_a_to_au, do_clear_b_to_au, do_clear_c_to_au,
    output do_not_a_to_au, do_sum_to_au, do_and_to_au,
    output do_right_shift_bc_to_au, do_move_b_to_c_to_au,
    output do_left_shift_c_to_au, do_left_shift_c29_to_au,
    output busy_to_op, done_to_op, ovf_to_op
  );
endinterface

// File: rtl/arith_step_counter.sv
// arith_step_counter: loadable down-counter with zero flag, shared
// by the MUL iteration loop and the SHLC distance loop.
module arith_step_counter #(
  parameter int CNT_W = 5
)(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   count <= '0;
    else if (load) count <= value;
    else if (dec)  count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/arith_ctrl.sv
// arith_ctrl: sequences ADD/SUB/AND/MUL/SHLC into unit strobes.
// Define ARITH_CTRL_OVF_EN to build the overflow flag.
module arith_ctrl
  import arith_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
)(
  input logic         clk,
  input logic         resetn,
  arith_ctrl_if.slave bus
);

  state_t           state, state_n;
  strobe_t          strb;
  logic [2:0]       op_q;
  logic             accept;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             busy_q, done_q;

  assign accept = (state == IDLE) && bus.start_from_op;

  arith_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .value  (cnt_val),
    .zero   (cnt_zero)
  );

  always_comb begin
    state_n  = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state)
      IDLE: if (bus.start_from_op) begin
        unique case (bus.op_sel_from_op)
          OP_ADD: state_n = SUM;
          OP_SUB: state_n = NOTA;
          OP_AND: state_n = AND;
          OP_MUL: state_n = CLRB;
          OP_SHLC: begin
            if (bus.shift_cnt_from_op == '0) begin
              state_n = DONE;
            end else begin
              state_n  = SHLC;
              cnt_load = 1'b1;
              cnt_val  = bus.shift_cnt_from_op - CNT_W'(1);
            end
          end
          default: state_n = DONE;
        endcase
      end
      NOTA: state_n = SUM;
      SUM:  state_n = (op_q == OP_MUL) ? SHIFT : MOVE;
      MOVE: state_n = DONE;
      AND:  state_n = DONE;
      CLRB: begin
        state_n  = TEST;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(WORD_W - 1);
      end
      TEST: state_n = bus.reg_c30_from_au ? SUM : SHIFT;
      SHIFT: begin
        if (cnt_zero) state_n = DONE;
        else begin
          state_n = TEST;
          cnt_dec = 1'b1;
        end
      end
      SHLC: begin
        if (cnt_zero) state_n = DONE;
        else cnt_dec = 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes come from flops loaded with the next state's decode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      strb   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      op_q   <= '0;
    end else begin
      state  <= state_n;
      strb   <= decode(state_n);
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == DONE);
      if (accept) op_q <= bus.op_sel_from_op;
    end
  end

`ifdef ARITH_CTRL_OVF_EN
  logic ovf_q, shift_d;

  // reg_b0 reflects a SHIFT only in the following cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q   <= 1'b0;
      shift_d <= 1'b0;
    end else begin
      shift_d <= (state == SHIFT);
      if (accept) ovf_q <= 1'b0;
      else if (state == SUM && op_q != OP_MUL)
        ovf_q <= bus.carry_out_from_au;
      else if (shift_d) ovf_q <= ovf_q | bus.reg_b0_from_au;
    end
  end

  assign bus.ovf_to_op = ovf_q;
`else
  logic unused_status;
  assign unused_status = ^{bus.carry_out_from_au, bus.reg_b0_from_au};
  assign bus.ovf_to_op = 1'b0;
`endif

  assign bus.do_clear_a_to_au        = strb.clear_a;
  assign bus.do_clear_b_to_au        = strb.clear_b;
  assign bus.do_clear_c_to_au        = strb.clear_c;
  assign bus.do_not_a_to_au          = strb.not_a;
  assign bus.do_sum_to_au            = strb.sum;
  assign bus.do_and_to_au            = strb.and_ab;
  assign bus.do_right_shift_bc_to_au = strb.right_shift_bc;
  assign bus.do_move_b_to_c_to_au    = strb.move_b_to_c;
  assign bus.do_left_shift_c_to_au   = strb.left_shift_c;
  assign bus.do_left_shift_c29_to_au = strb.left_shift_c29;
  assign bus.busy_to_op              = busy_q;
  assign bus.done_to_op              = done_q;

endmodule

// File: tb/tb_arith_ctrl.sv
// tb_arith_ctrl: scoreboard bench with a behavioural arithmetic unit
// answering the sequencer's strobes.
module tb_arith_ctrl;
  import arith_ctrl_pkg::*;

  localparam int W = WORD_W_DEF;
  localparam int CW = CNT_W_DEF;
`ifdef ARITH_CTRL_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] clra, clrb, clrc, nota, sum;
    logic [7:0] andb, rsh, move, lsc, lsc29;
  } cnt_t;

  typedef struct {
    string          name;
    int             issue;
    int             lat;
    cnt_t           cnt;
    logic [2*W-1:0] res;
    logic           ovf;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arith_ctrl_if #(.CNT_W(CW)) bus();

  arith_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Behavioural arithmetic unit: A, B, C registers plus carries.
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         cin = 1'b0, cy = 1'b0;
  logic         ld = 1'b0;
  logic [W-1:0] ld_a = '0, ld_b = '0, ld_c = '0;
  logic [W:0]   add_r;

  assign add_r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign bus.carry_out_from_au = add_r[W];
  assign bus.reg_b0_from_au    = b[W-1];
  assign bus.reg_c30_from_au   = c[0];

  always @(posedge clk) begin
    if (ld) begin
      a <= ld_a; b <= ld_b; c <= ld_c;
      cin <= 1'b0; cy <= 1'b0;
    end else begin
      if (bus.do_clear_a_to_au) a <= '0;
      if (bus.do_clear_b_to_au) begin b <= '0; cy <= 1'b0; end
      if (bus.do_clear_c_to_au) c <= '0;
      if (bus.do_not_a_to_au) begin a <= ~a; cin <= 1'b1; end
      if (bus.do_sum_to_au) begin {cy, b} <= add_r; cin <= 1'b0; end
      if (bus.do_and_to_au) b <= a & b;
      if (bus.do_right_shift_bc_to_au) begin
        {b, c} <= {cy, b, c[W-1:1]};
        cy <= 1'b0;
      end
      if (bus.do_move_b_to_c_to_au) c <= b;
      if (bus.do_left_shift_c_to_au) c <= {c[W-2:0], 1'b0};
    end
  end

  task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic cnt_t sig(int nota, int sum, int andb, int clrb,
                               int rsh, int move, int lsc);
    cnt_t s;
    s = '0;
    s.nota = 8'(nota); s.sum = 8'(sum); s.andb = 8'(andb);
    s.clrb = 8'(clrb); s.rsh = 8'(rsh); s.move = 8'(move);
    s.lsc = 8'(lsc); s.lsc29 = 8'(lsc);
    return s;
  endfunction

  function automatic logic [12:0] outs();
    return {bus.do_clear_a_to_au, bus.do_clear_b_to_au,
            bus.do_clear_c_to_au, bus.do_not_a_to_au,
            bus.do_sum_to_au, bus.do_and_to_au,
            bus.do_right_shift_bc_to_au, bus.do_move_b_to_c_to_au,
            bus.do_left_shift_c_to_au, bus.do_left_shift_c29_to_au,
            bus.busy_to_op, bus.done_to_op, bus.ovf_to_op};
  endfunction

  // Monitor: counts strobes per op, pops the scoreboard on done.
  initial begin
    cnt_t got;
    exp_t cur;
    int   multi;
    int   n;
    bit   pend;
    got = '0; multi = 0; pend = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        got = '0; multi = 0; pend = 0;
      end else begin
        if (pend) begin
          pend = 0;
          chk({cur.name, "_ovf"}, 128'(bus.ovf_to_op), 128'(cur.ovf));
        end
        got.clra  += 8'(bus.do_clear_a_to_au);
        got.clrb  += 8'(bus.do_clear_b_to_au);
        got.clrc  += 8'(bus.do_clear_c_to_au);
        got.nota  += 8'(bus.do_not_a_to_au);
        got.sum   += 8'(bus.do_sum_to_au);
        got.andb  += 8'(bus.do_and_to_au);
        got.rsh   += 8'(bus.do_right_shift_bc_to_au);
        got.move  += 8'(bus.do_move_b_to_c_to_au);
        got.lsc   += 8'(bus.do_left_shift_c_to_au);
        got.lsc29 += 8'(bus.do_left_shift_c29_to_au);
        n = int'(bus.do_clear_a_to_au) + int'(bus.do_clear_b_to_au)
          + int'(bus.do_clear_c_to_au) + int'(bus.do_not_a_to_au)
          + int'(bus.do_sum_to_au) + int'(bus.do_and_to_au)
          + int'(bus.do_right_shift_bc_to_au)
          + int'(bus.do_move_b_to_c_to_au)
          + int'(bus.do_left_shift_c_to_au);
        if (n > 1 || bus.do_left_shift_c29_to_au != bus.do_left_shift_c_to_au)
          multi++;
        if (bus.done_to_op) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 128'(1), 128'(0));
          end else begin
            cur = sb.pop_front();
            chk({cur.name, "_lat"}, 128'(cyc - cur.issue), 128'(cur.lat));
            chk({cur.name, "_strobes"}, 128'(got), 128'(cur.cnt));
            chk({cur.name, "_excl"}, 128'(multi), 128'(0));
            chk({cur.name, "_busy"}, 128'(bus.busy_to_op), 128'(1));
            chk({cur.name, "_res"}, 128'({b, c}), 128'(cur.res));
            pend = 1;
          end
          got = '0; multi = 0;
        end
      end
    end
  end

  task automatic wait_idle(string nm);
    int k;
    k = 0;
    while ((bus.busy_to_op || bus.done_to_op) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle_wait"}, 128'(k < 200), 128'(1));
  endtask

  task automatic push(string nm, int iss, int lat, cnt_t cn,
                      logic [2*W-1:0] res, logic ov);
    exp_t e;
    e.name = nm; e.issue = iss; e.lat = lat;
    e.cnt = cn; e.res = res; e.ovf = ov;
    sb.push_back(e);
  endtask

  task automatic drive(logic [2:0] op, logic [CW-1:0] n,
                       logic [W-1:0] va, logic [W-1:0] vb,
                       logic [W-1:0] vc);
    bus.start_from_op = 1'b1;
    bus.op_sel_from_op = op;
    bus.shift_cnt_from_op = n;
    ld = 1'b1; ld_a = va; ld_b = vb; ld_c = vc;
  endtask

  task automatic issue(string nm, logic [2:0] op, logic [CW-1:0] n,
                       logic [W-1:0] va, logic [W-1:0] vb,
                       logic [W-1:0] vc, int lat, cnt_t cn,
                       logic [2*W-1:0] res, logic ov);
    wait_idle(nm);
    push(nm, cyc, lat, cn, res, ov);
    drive(op, n, va, vb, vc);
    @(negedge clk);
    bus.start_from_op = 1'b0;
    ld = 1'b0;
  endtask

  initial begin
    int k;
    int s;
    bus.start_from_op = 1'b0;
    bus.op_sel_from_op = '0;
    bus.shift_cnt_from_op = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 128'(outs()), 128'(0));
    resetn = 1'b1;
    @(negedge clk);

    issue("add", OP_ADD, '0, W'(30'h3FFFFFFF), W'(1), W'(30'h155),
          3, sig(0, 1, 0, 0, 0, 1, 0), {W'(0), W'(0)}, OVF);
    issue("sub", OP_SUB, '0, W'(5), W'(7), W'(0),
          4, sig(1, 1, 0, 0, 0, 1, 0), {W'(2), W'(2)}, OVF);
    issue("and", OP_AND, '0, W'(12), W'(10), W'(0),
          2, sig(0, 0, 1, 0, 0, 0, 0), {W'(8), W'(0)}, 1'b0);
    issue("mul3x5", OP_MUL, '0, W'(3), W'(30'h123), W'(5),
          64, sig(0, 2, 0, 1, 30, 0, 0), {W'(0), W'(15)}, 1'b0);
    issue("shlc4", OP_SHLC, CW'(4), W'(0), W'(0), W'(1),
          5, sig(0, 0, 0, 0, 0, 0, 4), {W'(0), W'(16)}, 1'b0);
    issue("shlc0", OP_SHLC, CW'(0), W'(0), W'(0), W'(3),
          1, sig(0, 0, 0, 0, 0, 0, 0), {W'(0), W'(3)}, 1'b0);
    issue("nop", 3'd7, CW'(3), W'(1), W'(2), W'(3),
          1, sig(0, 0, 0, 0, 0, 0, 0), {W'(2), W'(3)}, 1'b0);

    // Start held through a MUL; an ADD follows in the first IDLE cycle.
    wait_idle("held");
    push("held_mul", cyc, 64, sig(0, 2, 0, 1, 30, 0, 0),
         {W'(0), W'(12)}, 1'b0);
    drive(OP_MUL, '0, W'(2), W'(0), W'(6));
    @(negedge clk);
    ld = 1'b0;
    k = 0;
    while (!bus.done_to_op && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("held_done_wait", 128'(k < 100), 128'(1));
    bus.op_sel_from_op = OP_ADD;
    push("b2b_add", cyc + 1, 3, sig(0, 1, 0, 0, 0, 1, 0),
         {W'(9), W'(9)}, 1'b0);
    @(negedge clk);
    ld = 1'b1; ld_a = W'(4); ld_b = W'(5); ld_c = W'(0);
    @(negedge clk);
    bus.start_from_op = 1'b0;
    ld = 1'b0;

    // Reset asserted during the 10th SHIFT of a MUL.
    issue("rst_mul", OP_MUL, '0, W'(3), W'(0), W'(5),
          64, sig(0, 2, 0, 1, 30, 0, 0), {W'(0), W'(15)}, 1'b0);
    k = 0; s = 0;
    while (s < 10 && k < 200) begin
      if (bus.do_right_shift_bc_to_au) s++;
      if (s < 10) begin
        @(negedge clk);
        k++;
      end
    end
    chk("rst_shift_wait", 128'(s), 128'(10));
    resetn = 1'b0;
    #1;
    chk("rst_mid_outs", 128'(outs()), 128'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue("post_rst_add", OP_ADD, '0, W'(1), W'(1), W'(0),
          3, sig(0, 1, 0, 0, 0, 1, 0), {W'(2), W'(2)}, 1'b0);

    k = 0;
    while ((sb.size() != 0 || bus.busy_to_op) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 128'(sb.size()), 128'(0));
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
